// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: serialises CPU LSU (port 0) and loader/debug (port 1)
// transactions onto the single RAM data port, absorbing its read latency.
module memory_port_arbiter #(
   parameter bit PRIORITY_MODE = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   input  logic [2:0]  writeMode0,
   input  logic [2:0]  writeMode1,
   input  logic [2:0]  readMode0,
   input  logic [2:0]  readMode1,
   input  logic        unsignedLoad0,
   input  logic        unsignedLoad1,
   output logic        ack0,
   output logic        ack1,
   output logic        err,
   output logic [31:0] rdata,
   output logic [31:0] mem_address,
   output logic [31:0] mem_data,
   output logic [2:0]  mem_writeMode,
   output logic [2:0]  mem_readMode,
   output logic        mem_unsignedLoad,
   input  logic [31:0] mem_dataOutput,
   output logic        busy,
   output logic        grant_id
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RESP
   } state_t;

   localparam logic [2:0] MODE_NONE = 3'd0;
   localparam logic [2:0] MODE_MAX  = 3'd5;

   state_t      state;
   state_t      state_nxt;

   logic [31:0] iss_addr;
   logic [31:0] iss_data;
   logic [2:0]  iss_wm;
   logic [2:0]  iss_rm;
   logic        iss_uns;
   logic        gid;
   logic        last;
   logic        rej;

   logic        win;
   logic        take;
   logic        legal;
   logic [31:0] s_addr;
   logic [31:0] s_data;
   logic [2:0]  s_wm;
   logic [2:0]  s_rm;
   logic        s_uns;
   logic        ack_any;

   // pick the winner and mux its request fields
   always_comb begin
      win = 1'b0;
      if (req0 && req1)
         win = PRIORITY_MODE ? 1'b0 : ~last;
      else
         win = req1;
      take   = (state == IDLE) && !rej && (req0 || req1);
      s_addr = win ? addr1 : addr0;
      s_data = win ? wdata1 : wdata0;
      s_wm   = win ? writeMode1 : writeMode0;
      s_rm   = win ? readMode1 : readMode0;
      s_uns  = win ? unsignedLoad1 : unsignedLoad0;
      legal  = (s_wm <= MODE_MAX) && (s_rm <= MODE_MAX) &&
               ((s_wm == MODE_NONE) != (s_rm == MODE_NONE));
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (take && legal) state_nxt = ISSUE;
         ISSUE:   state_nxt = (iss_wm != MODE_NONE) ? IDLE : RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // issue registers, grant tracking and pending-reject flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         iss_addr <= '0;
         iss_data <= '0;
         iss_wm   <= MODE_NONE;
         iss_rm   <= MODE_NONE;
         iss_uns  <= 1'b0;
         gid      <= 1'b0;
         last     <= 1'b1;
         rej      <= 1'b0;
      end else begin
         rej <= take && !legal;
         if (take) begin
            iss_addr <= s_addr;
            iss_data <= s_data;
            iss_wm   <= s_wm;
            iss_rm   <= s_rm;
            iss_uns  <= s_uns;
            gid      <= win;
            last     <= win;
         end
      end
   end

   // acks, read return and RAM port drive
   always_comb begin
      ack_any = ((state == ISSUE) && (iss_wm != MODE_NONE)) ||
                (state == RESP) || rej;
      ack0    = ack_any && !gid;
      ack1    = ack_any && gid;
      err     = rej;
      rdata   = (state == RESP) ? mem_dataOutput : 32'd0;
      mem_address      = iss_addr;
      mem_data         = iss_data;
      mem_unsignedLoad = iss_uns;
      mem_writeMode    = (state == ISSUE) ? iss_wm : MODE_NONE;
      mem_readMode     = (state == ISSUE) ? iss_rm : MODE_NONE;
      busy     = (state != IDLE);
      grant_id = gid;
   end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// tb_memory_port_arbiter: directed checks of the two-port RAM arbiter,
// round-robin instance with a small RAM model plus a fixed-priority instance.
module tb_memory_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        req0 = 0, req1 = 0;
   logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
   logic [2:0]  writeMode0 = 0, writeMode1 = 0, readMode0 = 0, readMode1 = 0;
   logic        unsignedLoad0 = 0, unsignedLoad1 = 0;
   logic        ack0, ack1, err, busy, grant_id, mem_unsignedLoad;
   logic [31:0] rdata, mem_address, mem_data;
   logic [2:0]  mem_writeMode, mem_readMode;
   logic [31:0] mem_dout = 32'd0;

   logic        p_req0 = 0, p_req1 = 0;
   logic [31:0] p_addr0 = 32'h100, p_addr1 = 32'h200;
   logic        p_ack0, p_ack1, p_err, p_busy, p_gid, p_uns;
   logic [31:0] p_rdata, p_maddr, p_mdata;
   logic [2:0]  p_mwm, p_mrm;
   logic [31:0] p_dout = 32'd0;

   logic [31:0] ram [0:63];
   logic [63:0] wvld = '0;
   logic [5:0]  idx;

   int n_chk  = 0;
   int n_fail = 0;
   int n0, n1;
   logic e0, e1;

   always #5 clk = ~clk;

   memory_port_arbiter #(.PRIORITY_MODE(1'b0)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1),
      .addr0(addr0), .addr1(addr1),
      .wdata0(wdata0), .wdata1(wdata1),
      .writeMode0(writeMode0), .writeMode1(writeMode1),
      .readMode0(readMode0), .readMode1(readMode1),
      .unsignedLoad0(unsignedLoad0), .unsignedLoad1(unsignedLoad1),
      .ack0(ack0), .ack1(ack1), .err(err), .rdata(rdata),
      .mem_address(mem_address), .mem_data(mem_data),
      .mem_writeMode(mem_writeMode), .mem_readMode(mem_readMode),
      .mem_unsignedLoad(mem_unsignedLoad),
      .mem_dataOutput(mem_dout),
      .busy(busy), .grant_id(grant_id)
   );

   memory_port_arbiter #(.PRIORITY_MODE(1'b1)) dutp (
      .clk(clk), .rst(rst),
      .req0(p_req0), .req1(p_req1),
      .addr0(p_addr0), .addr1(p_addr1),
      .wdata0(32'd0), .wdata1(32'd0),
      .writeMode0(3'd0), .writeMode1(3'd0),
      .readMode0(3'd3), .readMode1(3'd3),
      .unsignedLoad0(1'b0), .unsignedLoad1(1'b0),
      .ack0(p_ack0), .ack1(p_ack1), .err(p_err), .rdata(p_rdata),
      .mem_address(p_maddr), .mem_data(p_mdata),
      .mem_writeMode(p_mwm), .mem_readMode(p_mrm),
      .mem_unsignedLoad(p_uns),
      .mem_dataOutput(p_dout),
      .busy(p_busy), .grant_id(p_gid)
   );

   assign idx = mem_address[7:2];

   // RAM model: one-cycle read latency, unwritten words read as {4{idx}}
   always @(posedge clk) begin
      if (mem_writeMode == 3'd3) begin
         ram[idx]  <= mem_data;
         wvld[idx] <= 1'b1;
      end
      if (mem_readMode != 3'd0)
         mem_dout <= wvld[idx] ? ram[idx] : {4{2'b00, idx}};
   end

   // priority instance RAM returns the address it was given
   always @(posedge clk) p_dout <= p_maddr;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      // reset state
      tick();
      tick();
      chk("rst_ack0", 32'(ack0), 32'd0);
      chk("rst_ack1", 32'(ack1), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_maddr", mem_address, 32'd0);
      chk("rst_mdata", mem_data, 32'd0);
      chk("rst_mwm", 32'(mem_writeMode), 32'd0);
      chk("rst_mrm", 32'(mem_readMode), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_gid", 32'(grant_id), 32'd0);
      rst = 1'b0;
      tick();

      // port 0 write then read back
      req0 = 1; addr0 = 32'h10; wdata0 = 32'hDEADBEEF;
      writeMode0 = 3'd3; readMode0 = 3'd0;
      chk("wr_c1_ack0", 32'(ack0), 32'd0);
      chk("wr_c1_mwm", 32'(mem_writeMode), 32'd0);
      tick();
      chk("wr_c2_ack0", 32'(ack0), 32'd1);
      chk("wr_c2_err", 32'(err), 32'd0);
      chk("wr_c2_mwm", 32'(mem_writeMode), 32'd3);
      chk("wr_c2_maddr", mem_address, 32'h10);
      chk("wr_c2_mdata", mem_data, 32'hDEADBEEF);
      chk("wr_c2_busy", 32'(busy), 32'd1);
      tick();
      writeMode0 = 3'd0; readMode0 = 3'd3;
      chk("rd_c1_ack0", 32'(ack0), 32'd0);
      chk("rd_c1_mwm", 32'(mem_writeMode), 32'd0);
      tick();
      chk("rd_c2_ack0", 32'(ack0), 32'd0);
      chk("rd_c2_mrm", 32'(mem_readMode), 32'd3);
      chk("rd_c2_mwm", 32'(mem_writeMode), 32'd0);
      tick();
      chk("rd_c3_ack0", 32'(ack0), 32'd1);
      chk("rd_c3_rdata", rdata, 32'hDEADBEEF);
      chk("rd_c3_mrm", 32'(mem_readMode), 32'd0);
      tick();
      req0 = 0;
      chk("rd_after_ack0", 32'(ack0), 32'd0);
      chk("rd_after_busy", 32'(busy), 32'd0);

      // simultaneous reads right after reset
      rst = 1;
      tick();
      rst = 0;
      tick();
      req0 = 1; addr0 = 32'h10; readMode0 = 3'd3; writeMode0 = 3'd0;
      req1 = 1; addr1 = 32'h20; readMode1 = 3'd3; writeMode1 = 3'd0;
      tick();
      chk("bb_iss_gid", 32'(grant_id), 32'd0);
      chk("bb_iss_addr", mem_address, 32'h10);
      tick();
      chk("bb_r0_ack0", 32'(ack0), 32'd1);
      chk("bb_r0_ack1", 32'(ack1), 32'd0);
      chk("bb_r0_rdata", rdata, 32'hDEADBEEF);
      tick();
      req0 = 0;
      tick();
      chk("bb_iss1_gid", 32'(grant_id), 32'd1);
      chk("bb_iss1_addr", mem_address, 32'h20);
      chk("bb_iss1_ack1", 32'(ack1), 32'd0);
      tick();
      chk("bb_r1_ack1", 32'(ack1), 32'd1);
      chk("bb_r1_ack0", 32'(ack0), 32'd0);
      chk("bb_r1_rdata", rdata, 32'h08080808);
      tick();
      req1 = 0;

      // round-robin back-to-back writes, 8 per port
      n0 = 0; n1 = 0;
      readMode0 = 0; readMode1 = 0; writeMode0 = 3; writeMode1 = 3;
      addr0 = 32'h40; wdata0 = 32'hA0000000;
      addr1 = 32'h80; wdata1 = 32'hB0000000;
      req0 = 1; req1 = 1;
      for (int k = 0; k < 32; k++) begin
         e0 = (k % 2 == 1) && ((k / 2) % 2 == 0);
         e1 = (k % 2 == 1) && ((k / 2) % 2 == 1);
         chk("rr_ack0", 32'(ack0), 32'(e0));
         chk("rr_ack1", 32'(ack1), 32'(e1));
         if (e0) chk("rr_data0", mem_data, 32'hA0000000 | 32'(n0));
         if (e1) chk("rr_data1", mem_data, 32'hB0000000 | 32'(n1));
         if (e0 || e1) chk("rr_gid", 32'(grant_id), 32'(e1));
         tick();
         if (e0) begin
            n0++;
            if (n0 == 8) req0 = 0;
            addr0 = 32'h40 + 32'(4 * n0);
            wdata0 = 32'hA0000000 | 32'(n0);
         end
         if (e1) begin
            n1++;
            if (n1 == 8) req1 = 0;
            addr1 = 32'h80 + 32'(4 * n1);
            wdata1 = 32'hB0000000 | 32'(n1);
         end
      end
      chk("rr_idle", 32'(busy), 32'd0);

      // fixed priority: four port-0 reads before port 1
      p_req0 = 1; p_req1 = 1;
      for (int k = 1; k <= 15; k++) begin
         e0 = (k % 3 == 0) && (k <= 12);
         e1 = (k == 15);
         chk("pr_ack0", 32'(p_ack0), 32'(e0));
         chk("pr_ack1", 32'(p_ack1), 32'(e1));
         if (e0) chk("pr_rdata0", p_rdata, 32'h100);
         if (e1) chk("pr_rdata1", p_rdata, 32'h200);
         tick();
         if (k == 12) p_req0 = 0;
      end
      p_req1 = 0;

      // port 1 illegal: write and read mode together
      req1 = 1; addr1 = 32'h30; writeMode1 = 3'd3; readMode1 = 3'd1;
      chk("ill_c1_ack1", 32'(ack1), 32'd0);
      chk("ill_c1_mwm", 32'(mem_writeMode), 32'd0);
      tick();
      chk("ill_c2_ack1", 32'(ack1), 32'd1);
      chk("ill_c2_err", 32'(err), 32'd1);
      chk("ill_c2_ack0", 32'(ack0), 32'd0);
      chk("ill_c2_mwm", 32'(mem_writeMode), 32'd0);
      chk("ill_c2_mrm", 32'(mem_readMode), 32'd0);
      chk("ill_c2_busy", 32'(busy), 32'd0);
      tick();
      req1 = 0;
      chk("ill_c3_ack1", 32'(ack1), 32'd0);
      chk("ill_c3_err", 32'(err), 32'd0);
      chk("ill_c3_mwm", 32'(mem_writeMode), 32'd0);
      chk("ill_c3_mrm", 32'(mem_readMode), 32'd0);
      chk("ill_c3_busy", 32'(busy), 32'd0);

      // port 0 illegal: read mode out of range
      req0 = 1; addr0 = 32'h10; writeMode0 = 3'd0; readMode0 = 3'd6;
      tick();
      chk("oor_ack0", 32'(ack0), 32'd1);
      chk("oor_err", 32'(err), 32'd1);
      chk("oor_mrm", 32'(mem_readMode), 32'd0);
      tick();
      req0 = 0;
      chk("oor_c3_ack0", 32'(ack0), 32'd0);

      // reset during RESP of a port-0 read
      req0 = 1; addr0 = 32'h10; readMode0 = 3'd3;
      tick();
      chk("ab_iss_mrm", 32'(mem_readMode), 32'd3);
      tick();
      rst = 1;
      #1;
      chk("ab_ack0", 32'(ack0), 32'd0);
      chk("ab_busy", 32'(busy), 32'd0);
      chk("ab_rdata", rdata, 32'd0);
      chk("ab_maddr", mem_address, 32'd0);
      chk("ab_gid", 32'(grant_id), 32'd0);
      req0 = 0;
      tick();
      chk("ab_hold_ack0", 32'(ack0), 32'd0);
      rst = 0;
      tick();
      req0 = 1; addr0 = 32'h10; readMode0 = 3'd3;
      req1 = 1; addr1 = 32'h20; readMode1 = 3'd3; writeMode1 = 3'd0;
      tick();
      chk("ab_next_gid", 32'(grant_id), 32'd0);
      chk("ab_next_addr", mem_address, 32'h10);
      tick();
      chk("ab_next_ack0", 32'(ack0), 32'd1);
      chk("ab_next_ack1", 32'(ack1), 32'd0);
      tick();
      req0 = 0; req1 = 0;
      tick();
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
